// File: rtl/seq_col_permute.sv
// Sequential column-permutation stage for sorted QR: scans column norms from start_col
// for the min (or max) and swaps that column (or complex column pair) into start_col.
module seq_col_permute #(
   parameter int DIM     = 8,
   parameter int WL      = 16,
   parameter int NORM_WL = 7,
   parameter int ORD_W   = 3,
   parameter int PAIR    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ORD_W-1:0]         start_col,
   input  logic                     mode_max,
   input  logic [DIM*DIM*WL-1:0]    Hmatrix_i,
   input  logic [DIM*NORM_WL-1:0]   colnorm_i,
   input  logic [DIM*ORD_W-1:0]     colorder_i,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DIM*DIM*WL-1:0]    Hmatrix_o,
   output logic [DIM*NORM_WL-1:0]   colnorm_o,
   output logic [DIM*ORD_W-1:0]     colorder_o,
   output logic [ORD_W-1:0]         sel_col_o,
   output logic                     swapped_o,
   output logic                     err_o
);

   localparam int             STRIDE = (PAIR != 0) ? 2 : 1;
   localparam logic [ORD_W:0] STEP   = (ORD_W+1)'(STRIDE);
   localparam logic [ORD_W:0] LAST   = (ORD_W+1)'(DIM - STRIDE);

   typedef enum logic [1:0] {IDLE, SCAN, SWAP, DONE} state_t;
   state_t state, state_nxt;

   // Packed views match the flat port packing: element (r,c) is hm[r][c].
   logic [DIM-1:0][DIM-1:0][WL-1:0] hm_q, hm_sw;
   logic [DIM-1:0][NORM_WL-1:0]     nm_q, nm_sw;
   logic [DIM-1:0][ORD_W-1:0]       od_q, od_sw;
   logic [ORD_W-1:0]                start_q, best_q, start_p1, best_p1;
   logic [ORD_W:0]                  idx_q, start_ext, first_idx;
   logic                            mode_q, err_q;
   logic                            accept, start_err, better;
   logic [NORM_WL-1:0]              cand_n, best_n;

   assign in_ready  = (state == IDLE) & ~rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;

   assign start_ext = {1'b0, start_col};
   assign first_idx = start_ext + STEP;
   assign start_err = (start_ext > LAST) || ((PAIR != 0) && start_col[0]);

   // Strict compares: a tie never displaces the lower-index incumbent.
   assign cand_n = nm_q[idx_q[ORD_W-1:0]];
   assign best_n = nm_q[best_q];
   assign better = mode_q ? (cand_n > best_n) : (cand_n < best_n);

   assign start_p1 = start_q + ORD_W'(1);
   assign best_p1  = best_q + ORD_W'(1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)
                  state_nxt = (!start_err && first_idx <= LAST) ? SCAN : SWAP;
         SCAN: if (idx_q == LAST) state_nxt = SWAP;
         SWAP: state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // best == start (no winner or error) makes every exchange below an identity.
   always_comb begin
      hm_sw = hm_q;
      nm_sw = nm_q;
      od_sw = od_q;
      for (int r = 0; r < DIM; r++) begin
         hm_sw[r][start_q] = hm_q[r][best_q];
         hm_sw[r][best_q]  = hm_q[r][start_q];
         if (PAIR != 0) begin
            hm_sw[r][start_p1] = hm_q[r][best_p1];
            hm_sw[r][best_p1]  = hm_q[r][start_p1];
         end
      end
      nm_sw[start_q] = nm_q[best_q];
      nm_sw[best_q]  = nm_q[start_q];
      od_sw[start_q] = od_q[best_q];
      od_sw[best_q]  = od_q[start_q];
      if (PAIR != 0) begin
         nm_sw[start_p1] = nm_q[best_p1];
         nm_sw[best_p1]  = nm_q[start_p1];
         od_sw[start_p1] = od_q[best_p1];
         od_sw[best_p1]  = od_q[start_p1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hm_q       <= '0;
         nm_q       <= '0;
         od_q       <= '0;
         start_q    <= '0;
         best_q     <= '0;
         idx_q      <= '0;
         mode_q     <= 1'b0;
         err_q      <= 1'b0;
         Hmatrix_o  <= '0;
         colnorm_o  <= '0;
         colorder_o <= '0;
         sel_col_o  <= '0;
         swapped_o  <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               hm_q    <= Hmatrix_i;
               nm_q    <= colnorm_i;
               od_q    <= colorder_i;
               start_q <= start_col;
               best_q  <= start_col;
               idx_q   <= first_idx;
               mode_q  <= mode_max;
               err_q   <= start_err;
            end
            SCAN: begin
               if (better) best_q <= idx_q[ORD_W-1:0];
               idx_q <= idx_q + STEP;
            end
            SWAP: begin
               Hmatrix_o  <= hm_sw;
               colnorm_o  <= nm_sw;
               colorder_o <= od_sw;
               sel_col_o  <= best_q;
               swapped_o  <= (best_q != start_q);
               err_o      <= err_q;
            end
            default: ;
         endcase
      end
   end

endmodule
